// File: rtl/pes_pump_driver.sv
// Pump motor driver for the plant-watering controller: enforces minimum and maximum
// on-time, a mandatory cooldown, and a lockout after repeated timed-out runs.
module pes_pump_driver #(
  parameter int unsigned MIN_ON       = 4,
  parameter int unsigned MAX_ON       = 16,
  parameter int unsigned COOLDOWN     = 8,
  parameter int unsigned MAX_TIMEOUTS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       water_pump,
  input  logic       tank_empty,
  input  logic       clear_fault,
  output logic       pump_en,
  output logic [1:0] state,
  output logic       timeout_pulse,
  output logic       lockout,
  output logic [7:0] run_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;
  localparam logic [1:0] ST_LOCK = 2'd3;

  localparam logic [7:0] MIN_ON_C   = 8'(MIN_ON);
  localparam logic [7:0] MAX_ON_C   = 8'(MAX_ON);
  localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);
  localparam logic [1:0] MAX_TO_C   = 2'(MAX_TIMEOUTS);

  logic [1:0] state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [1:0] to_cnt_reg, to_cnt_next;
  logic [7:0] run_count_reg, run_count_next;
  logic       pump_en_reg, lockout_reg, timeout_reg, timeout_next;
  logic [1:0] to_cnt_inc;
  logic [7:0] run_count_inc;

  assign to_cnt_inc    = to_cnt_reg + 2'd1;
  assign run_count_inc = (run_count_reg == 8'hFF) ? run_count_reg : run_count_reg + 8'd1;

  // cnt_reg is 1 in the first cycle of RUN/COOL, so an exit compare against N gives N cycles.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    to_cnt_next    = to_cnt_reg;
    run_count_next = run_count_reg;
    timeout_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = 8'd0;
        if (water_pump && !tank_empty) begin
          state_next = ST_RUN;
          cnt_next   = 8'd1;
        end
      end
      ST_RUN: begin
        if (tank_empty) begin
          state_next = ST_LOCK;
          cnt_next   = 8'd0;
        end else if (cnt_reg == MAX_ON_C) begin
          timeout_next = 1'b1;
          to_cnt_next  = to_cnt_inc;
          if (to_cnt_inc == MAX_TO_C) begin
            state_next = ST_LOCK;
            cnt_next   = 8'd0;
          end else begin
            state_next     = ST_COOL;
            cnt_next       = 8'd1;
            run_count_next = run_count_inc;
          end
        end else if (!water_pump && (cnt_reg >= MIN_ON_C)) begin
          state_next     = ST_COOL;
          cnt_next       = 8'd1;
          to_cnt_next    = 2'd0;
          run_count_next = run_count_inc;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_COOL: begin
        if (cnt_reg == COOLDOWN_C) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        cnt_next = 8'd0;
        if (clear_fault && !tank_empty) begin
          state_next  = ST_IDLE;
          to_cnt_next = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 8'd0;
      to_cnt_reg    <= 2'd0;
      run_count_reg <= 8'd0;
      pump_en_reg   <= 1'b0;
      lockout_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      to_cnt_reg    <= to_cnt_next;
      run_count_reg <= run_count_next;
      pump_en_reg   <= (state_next == ST_RUN);
      lockout_reg   <= (state_next == ST_LOCK);
      timeout_reg   <= timeout_next;
    end
  end

  assign pump_en       = pump_en_reg;
  assign state         = state_reg;
  assign timeout_pulse = timeout_reg;
  assign lockout       = lockout_reg;
  assign run_count     = run_count_reg;

endmodule
